fb_arbiter: RTL
===============

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 6144 (14'h1800), framebuffer depth in bytes.
REQ-002 SHALL have parameter STALL_MAX, default 1023, maximum wait cycles before the stall flag sets.
REQ-003 CLK_FAST  in  1  single clock; all state changes on its rising edge.
REQ-004 RESET  in  1  reset, asynchronous and active-high.
REQ-005 CMD_VALID  in  1  CPU command available from the command FIFO.
REQ-006 CMD_READY  out  1  block accepts a command this cycle.
REQ-007 CMD_REG  in  3  register select: 0 CTRL, 1 ADDR_LOW, 2 ADDR_HIGH, 3 DATA, 4-7 ignored.
REQ-008 CMD_DATA  in  8  command payload.
REQ-009 DISP_REQ  in  1  display fetch request (active-display/prefetch window).
REQ-010 DISP_ADDR  in  13  display fetch address.
REQ-011 DISP_DATA  out  8  fetched byte.
REQ-012 DISP_VALID  out  1  DISP_DATA holds the byte for the previous cycle's DISP_REQ.
REQ-013 RAM_ADDR  out  13  framebuffer address.
REQ-014 RAM_WDATA  out  8  framebuffer write data.
REQ-015 RAM_WE  out  1  framebuffer write strobe.
REQ-016 RAM_RDATA  in  8  framebuffer read data, valid 1 cycle after RAM_ADDR.
REQ-017 ADDR_REG  out  14  current CPU address (drives the hardware cursor).
REQ-018 MODE  out  2  display mode from CTRL[1:0].
REQ-019 STALL  out  1  sticky flag: a DATA write waited more than STALL_MAX cycles.

Function
REQ-020 SHALL implement FSM states IDLE, DECODE, WRITE, INCR.
REQ-021 CMD_READY SHALL be 1 only in IDLE; a command is accepted when CMD_VALID&CMD_READY, capturing CMD_REG/CMD_DATA and moving to DECODE.
REQ-022 DECODE, CTRL: MODE<=data[1:0], incr_code<=data[6:2] (5 bits, only [3:0] used), incr_neg<=data[7]; next state IDLE.
REQ-023 DECODE, ADDR_LOW: ADDR_REG[5:0]<=data[5:0], upper bits unchanged; next state IDLE.
REQ-024 DECODE, ADDR_HIGH: ADDR_REG[13:6]<=data; next state IDLE.
REQ-025 DECODE, DATA: next state WRITE; DECODE, registers 4-7: next state IDLE with no side effect.
REQ-026 Display priority: whenever DISP_REQ=1, RAM_ADDR=DISP_ADDR and RAM_WE=0, regardless of FSM state.
REQ-027 WRITE: in the first cycle with DISP_REQ=0, RAM_ADDR=ADDR_REG[12:0], RAM_WDATA=captured data, RAM_WE=1 for exactly 1 cycle if ADDR_REG<RAM_SIZE; otherwise the write is suppressed. Both cases then go to INCR.
REQ-028 The wait counter SHALL count WRITE cycles blocked by DISP_REQ, clear on entry to WRITE, and saturate; STALL SHALL set when the counter exceeds STALL_MAX and clear only on RESET.
REQ-029 Increment table by incr_code[3:0]: 0->0; 1..8->1<<(code-1); 9->3; 10->10; 11->40; 12->80; 13->160; 14->120; 15->240.
REQ-030 INCR positive: sum=ADDR_REG+inc computed 15-bit; if sum>=RAM_SIZE, ADDR_REG<=sum-RAM_SIZE, else ADDR_REG<=sum.
REQ-031 INCR negative: if ADDR_REG<inc, ADDR_REG<=ADDR_REG+RAM_SIZE-inc, else ADDR_REG<=ADDR_REG-inc.
REQ-032 INCR SHALL go to IDLE; throughput is at most one DATA command per 4 cycles with no display contention.
REQ-033 DISP_VALID SHALL be DISP_REQ delayed 1 cycle; DISP_DATA<=RAM_RDATA when DISP_VALID, otherwise held.
REQ-034 When RAM_WE=0 and DISP_REQ=0, RAM_ADDR SHALL equal ADDR_REG[12:0].

Reset
REQ-035 On RESET=1, asynchronously: state IDLE, CMD_READY=1 after release, ADDR_REG=0, MODE=1, incr_code=1, incr_neg=0, RAM_WE=0, DISP_VALID=0, DISP_DATA=0, STALL=0, wait counter=0.
REQ-036 RESET mid-WRITE SHALL drop RAM_WE immediately and discard the pending command; no increment occurs.

Verification
REQ-037 ADDR_HIGH 0x01, ADDR_LOW 0x05, DATA 0x41 -> one RAM_WE at addr 0x045 with data 0x41; ADDR_REG=0x046.
REQ-038 DISP_REQ held high for 20 cycles during a pending DATA -> RAM_WE=0 throughout, RAM_ADDR tracks DISP_ADDR; write occurs on the first cycle DISP_REQ=0; DISP_VALID lags DISP_REQ by 1 cycle.
REQ-039 CTRL 0x30 (code 12, +80), ADDR_REG=0x17F0, DATA -> ADDR_REG=0x0040 (wrap).
REQ-040 CTRL 0x84 (code 1, negative), ADDR_REG=0, DATA -> ADDR_REG=0x17FF.
REQ-041 ADDR_REG=0x1900, DATA -> no RAM_WE, ADDR_REG=0x0101 (0x1901-0x1800).
REQ-042 DISP_REQ=1 for STALL_MAX+2 cycles with a pending DATA -> STALL=1 and it stays 1 until RESET; RESET asserted during WRITE -> RAM_WE=0 the same cycle and ADDR_REG=0.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter: framebuffer arbiter between a CPU command stream and display fetch.
// The display always wins the RAM port; CPU DATA writes wait in WRITE until the
// display releases the port, then auto-increment the CPU address with wrap.
//
// Ports:
//   CLK_FAST    in   1   clock
//   RESET       in   1   asynchronous active-high reset
//   CMD_VALID   in   1   command available
//   CMD_READY   out  1   command accepted this cycle (IDLE only)
//   CMD_REG     in   3   register select (0 CTRL, 1 ADDR_LOW, 2 ADDR_HIGH, 3 DATA)
//   CMD_DATA    in   8   command payload
//   DISP_REQ    in   1   display fetch request
//   DISP_ADDR   in  13   display fetch address
//   DISP_DATA   out  8   fetched display byte
//   DISP_VALID  out  1   DISP_REQ delayed one cycle
//   RAM_ADDR    out 13   framebuffer address
//   RAM_WDATA   out  8   framebuffer write data
//   RAM_WE      out  1   framebuffer write strobe
//   RAM_RDATA   in   8   framebuffer read data (one cycle latency)
//   ADDR_REG    out 14   current CPU address
//   MODE        out  2   display mode
//   STALL       out  1   sticky: a DATA write waited too long
module fb_arbiter #(
    parameter int RAM_SIZE  = 6144,
    parameter int STALL_MAX = 1023
) (
    input  logic        CLK_FAST,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [2:0]  CMD_REG,
    input  logic [7:0]  CMD_DATA,
    input  logic        DISP_REQ,
    input  logic [12:0] DISP_ADDR,
    output logic [7:0]  DISP_DATA,
    output logic        DISP_VALID,
    output logic [12:0] RAM_ADDR,
    output logic [7:0]  RAM_WDATA,
    output logic        RAM_WE,
    input  logic [7:0]  RAM_RDATA,
    output logic [13:0] ADDR_REG,
    output logic [1:0]  MODE,
    output logic        STALL
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_INCR   = 2'd3;

    // Wide enough to hold STALL_MAX+1 so the "exceeded" condition is reachable.
    localparam int unsigned WW = $clog2(STALL_MAX + 2);
    localparam logic [WW-1:0] STALL_LIM = WW'(STALL_MAX);
    localparam logic [14:0]   SIZE15    = 15'(RAM_SIZE);

    logic [1:0]    state_q, state_d;
    logic [2:0]    reg_q, reg_d;
    logic [7:0]    data_q, data_d;
    logic [13:0]   addr_q, addr_d;
    logic [1:0]    mode_q, mode_d;
    logic [4:0]    code_q, code_d;
    logic          neg_q, neg_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          stall_q, stall_d;
    logic          dv_q;
    logic [7:0]    dd_q;

    logic [7:0]  inc;
    logic [14:0] inc15, addr15, sum, pos_addr, neg_addr;
    logic        in_range;

    // Address step selected by incr_code[3:0]; bit 4 is stored but unused.
    always_comb begin
        inc = '0;
        case (code_q[3:0])
            4'd0:    inc = 8'd0;
            4'd9:    inc = 8'd3;
            4'd10:   inc = 8'd10;
            4'd11:   inc = 8'd40;
            4'd12:   inc = 8'd80;
            4'd13:   inc = 8'd160;
            4'd14:   inc = 8'd120;
            4'd15:   inc = 8'd240;
            default: inc = 8'd1 << (code_q[3:0] - 4'd1);
        endcase
    end

    assign inc15    = {7'd0, inc};
    assign addr15   = {1'b0, addr_q};
    assign sum      = addr15 + inc15;
    assign pos_addr = (sum >= SIZE15) ? (sum - SIZE15) : sum;
    assign neg_addr = (addr15 < inc15) ? (addr15 + SIZE15 - inc15) : (addr15 - inc15);
    assign in_range = addr15 < SIZE15;

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        data_d  = data_q;
        addr_d  = addr_q;
        mode_d  = mode_q;
        code_d  = code_q;
        neg_d   = neg_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    reg_d   = CMD_REG;
                    data_d  = CMD_DATA;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_IDLE;
                case (reg_q)
                    3'd0: begin
                        mode_d = data_q[1:0];
                        code_d = data_q[6:2];
                        neg_d  = data_q[7];
                    end
                    3'd1: addr_d[5:0]  = data_q[5:0];
                    3'd2: addr_d[13:6] = data_q;
                    3'd3: begin
                        wait_d  = '0;
                        state_d = S_WRITE;
                    end
                    default: ;
                endcase
            end
            S_WRITE: begin
                if (DISP_REQ) begin
                    if (wait_q != '1) wait_d = wait_q + 1'b1;
                end else begin
                    state_d = S_INCR;
                end
            end
            default: begin
                addr_d  = neg_q ? neg_addr[13:0] : pos_addr[13:0];
                state_d = S_IDLE;
            end
        endcase
    end

    // Looks at the next count so STALL sets on the same edge the limit is passed.
    assign stall_d = stall_q | (wait_d > STALL_LIM);

    always_ff @(posedge CLK_FAST or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            reg_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            mode_q  <= 2'd1;
            code_q  <= 5'd1;
            neg_q   <= 1'b0;
            wait_q  <= '0;
            stall_q <= 1'b0;
            dv_q    <= 1'b0;
            dd_q    <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            code_q  <= code_d;
            neg_q   <= neg_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            dv_q    <= DISP_REQ;
            if (dv_q) dd_q <= RAM_RDATA;
        end
    end

    // Strobe is decoded from the state register so an async reset drops it at once.
    assign RAM_WE     = (state_q == S_WRITE) && !DISP_REQ && in_range;
    assign RAM_ADDR   = DISP_REQ ? DISP_ADDR : addr_q[12:0];
    assign RAM_WDATA  = data_q;
    assign CMD_READY  = (state_q == S_IDLE);
    assign DISP_VALID = dv_q;
    assign DISP_DATA  = dd_q;
    assign ADDR_REG   = addr_q;
    assign MODE       = mode_q;
    assign STALL      = stall_q;

endmodule
